hier_node_rr_hub: RTL
=====================

# hier_node_rr_hub

Parametrised hierarchy hub node: the generalised successor of the fixed five-child root node. It owns `NUM_CHILD` leaf channels instead of a hard-wired set. Each channel has a one-entry capture slot, a saturating event counter and a sticky overflow flag. Captured events are merged onto one valid/ready output stream by a round-robin arbiter. The hub sits between a generated child level and the next level up, so hubs can be cascaded to any depth.

## Interface
- `NUM_CHILD`, 5, number of child channels (2..32)
- `DATA_W`, 8, payload width per child event
- `CNT_W`, 16, per-child event counter width
- `ID_W`, $clog2(NUM_CHILD), width of the channel index
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; all state resets asynchronously on `rst_n`=0.
- `en`  in  1  capture enable. When low, child events are ignored; draining continues.
- `clear`  in  1  synchronous clear of the counters and overflow flags
- `child_evt`  in  NUM_CHILD  per-child event strobe, one cycle per event
- `child_data`  in  NUM_CHILD*DATA_W  per-child payload; child i uses bits [i*DATA_W +: DATA_W]
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  downstream accept
- `out_id`  out  ID_W  index of the source channel
- `out_data`  out  DATA_W  captured payload
- `out_count`  out  CNT_W  source counter value including this event
- `overflow`  out  NUM_CHILD  sticky per-channel drop flag

## Operation
- **Slot capture:** in a cycle with `en`=1 and `child_evt[i]`=1, the event is handled as follows.
  - If slot i is empty, or is being granted this cycle, the slot captures `child_data[i]` and `cnt[i]`+1 (saturating at 2^CNT_W-1), and `cnt[i]` increments (saturating).
  - Otherwise the event is dropped, `overflow[i]` is set, and `cnt[i]` is unchanged.
- **Arbiter:** round-robin over full slots. The priority pointer `ptr` resets to 0. The search order is ptr, ptr+1, … mod NUM_CHILD. After a grant to channel g, ptr = (g+1) mod NUM_CHILD. The pointer is unchanged when there is no grant.
- **Grant condition:** at least one slot is full AND (`out_valid`=0 OR `out_ready`=1).
- **Grant effect:** the granted slot empties. Its id, data and count load into the output register.
- **Output register:** `out_valid` sets on a grant. It clears on `out_valid`&&`out_ready` when there is no new grant in the same cycle. The out_* fields hold stable while `out_valid`=1 and `out_ready`=0.
- **`clear`=1:**
  - zeroes all `cnt` and `overflow` bits;
  - does not touch slots, the output register or `ptr`;
  - an event in the same cycle is captured with count 1, and cnt becomes 1.
- **`en`=0:** no capture, no count, no overflow. The arbiter and output keep draining.
- **Reset values:** `out_valid`=0, `out_id`=0, `out_data`=0, `out_count`=0, `overflow`=0, all slots empty, all counters 0, `ptr`=0.
- **Reset mid-operation:** pending slot contents and the output word are discarded. No partial transfer is visible after deassertion.

## Timing
- **Latency:** `child_evt` in cycle t gives `out_valid` in cycle t+2, provided the output is free and no higher-priority slot is full.
- **Throughput:** one word per cycle when `out_ready` is held high.
- **Slot turnaround:** a slot refilled in its grant cycle is eligible again the following cycle.
- **Backpressure:** with `out_ready`=0, at most NUM_CHILD+1 events are buffered (slots plus the output register). Any further events on full channels set their overflow bits.
- **Fairness bound:** a full slot is granted within NUM_CHILD grants.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset values:** reset, then idle -> all outputs 0.
- **Single event:** NUM_CHILD=5; `child_evt[2]` with data 0xA5 in cycle 3 -> cycle 5 shows `out_valid`=1, `out_id`=2, `out_data`=0xA5, `out_count`=1.
- **Round-robin order:** all five channels fire together with `out_ready`=1 -> ids 0,1,2,3,4 on consecutive cycles. A second burst after a grant to 2 is ordered from ptr=3.
- **Backpressure and overflow:** `out_ready`=0; channel 1 fires 3 times -> the first goes to the output register, the second to the slot, the third is dropped with `overflow[1]`=1. Release `out_ready` -> counts 1, 2 delivered.
- **Saturation:** CNT_W=4; 20 drained events on channel 0 -> `out_count` sequence 1..15, then 15 repeated.
- **Clear and en:** `clear` together with an event -> count 1, overflow zeroed. `en`=0 with events -> no output and counters unchanged. `rst_n` low mid-burst -> outputs 0 immediately.

Source files
------------

// File: rtl/hier_node_rr_hub.sv
// Hierarchy hub node: NUM_CHILD one-entry capture slots with saturating
// per-channel counters, merged onto one valid/ready stream by round-robin.
module hier_node_rr_hub #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 16,
    parameter int ID_W      = $clog2(NUM_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        clear,
    input  logic [NUM_CHILD-1:0]        child_evt,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ID_W-1:0]             out_id,
    output logic [DATA_W-1:0]           out_data,
    output logic [CNT_W-1:0]            out_count,
    output logic [NUM_CHILD-1:0]        overflow
);

    logic [NUM_CHILD-1:0] r_full;
    logic [NUM_CHILD-1:0] r_ovf;
    logic [DATA_W-1:0]    r_sdata [NUM_CHILD];
    logic [CNT_W-1:0]     r_scnt  [NUM_CHILD];
    logic [CNT_W-1:0]     r_cnt   [NUM_CHILD];
    logic [ID_W-1:0]      r_ptr;
    logic                 r_valid;
    logic [ID_W-1:0]      r_id;
    logic [DATA_W-1:0]    r_data;
    logic [CNT_W-1:0]     r_count;

    logic                 w_found;
    logic                 w_take;
    logic [ID_W-1:0]      w_gnt;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [NUM_CHILD-1:0] w_gvec;
    logic [NUM_CHILD-1:0] w_cap;
    logic [NUM_CHILD-1:0] w_drop;
    logic [CNT_W-1:0]     w_base [NUM_CHILD];
    logic [CNT_W-1:0]     w_inc  [NUM_CHILD];

    // Rotating search starting at r_ptr; first full slot wins.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_gnt   = '0;
        idx     = 0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_CHILD) idx = idx - NUM_CHILD;
            if (!w_found && r_full[idx]) begin
                w_found = 1'b1;
                w_gnt   = ID_W'(idx);
            end
        end
        w_take    = w_found && (!r_valid || out_ready);
        w_ptr_nxt = (w_gnt == ID_W'(NUM_CHILD - 1)) ? '0 : w_gnt + 1'b1;
        w_gvec    = '0;
        if (w_take) w_gvec[w_gnt] = 1'b1;
    end

    // A slot being granted this cycle can take a new event at once.
    always_comb begin
        for (int i = 0; i < NUM_CHILD; i++) begin
            w_base[i] = clear ? '0 : r_cnt[i];
            w_inc[i]  = (&w_base[i]) ? w_base[i] : w_base[i] + 1'b1;
            w_cap[i]  = en && child_evt[i] && (!r_full[i] || w_gvec[i]);
            w_drop[i] = en && child_evt[i] && !w_cap[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= '0;
            r_ovf   <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM_CHILD; i++) begin
                r_sdata[i] <= '0;
                r_scnt[i]  <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            if (w_take) begin
                r_ptr   <= w_ptr_nxt;
                r_valid <= 1'b1;
                r_id    <= w_gnt;
                r_data  <= r_sdata[w_gnt];
                r_count <= r_scnt[w_gnt];
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            for (int i = 0; i < NUM_CHILD; i++) begin
                if (w_cap[i]) begin
                    r_full[i]  <= 1'b1;
                    r_sdata[i] <= child_data[i*DATA_W +: DATA_W];
                    r_scnt[i]  <= w_inc[i];
                    r_cnt[i]   <= w_inc[i];
                end else begin
                    if (w_gvec[i]) r_full[i] <= 1'b0;
                    r_cnt[i] <= w_base[i];
                end
                r_ovf[i] <= (r_ovf[i] && !clear) || w_drop[i];
            end
        end
    end

    assign out_valid = r_valid;
    assign out_id    = r_id;
    assign out_data  = r_data;
    assign out_count = r_count;
    assign overflow  = r_ovf;

endmodule
